// File: rtl/mcif_rd_arb2.sv
`default_nettype none
// ============================================================================
// Module      : mcif_rd_arb2
// Description : Two-client round-robin read arbiter with in-order
//               outstanding-ID FIFO steering returned read data to its owner.
// Revision    : 1.0 - initial release
// ============================================================================
module mcif_rd_arb2 #(
    parameter int AW        = 32,
    parameter int LW        = 8,
    parameter int DW        = 128,
    parameter int OSD_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c0_cmd_valid,
    output logic          c0_cmd_ready,
    input  logic [AW-1:0] c0_cmd_addr,
    input  logic [LW-1:0] c0_cmd_len,
    input  logic          c1_cmd_valid,
    output logic          c1_cmd_ready,
    input  logic [AW-1:0] c1_cmd_addr,
    input  logic [LW-1:0] c1_cmd_len,
    output logic          c0_rd_valid,
    input  logic          c0_rd_ready,
    output logic [DW-1:0] c0_rd_data,
    output logic          c0_rd_last,
    output logic          c1_rd_valid,
    input  logic          c1_rd_ready,
    output logic [DW-1:0] c1_rd_data,
    output logic          c1_rd_last,
    output logic          m_ar_valid,
    input  logic          m_ar_ready,
    output logic [AW-1:0] m_ar_addr,
    output logic [LW-1:0] m_ar_len,
    input  logic          m_r_valid,
    output logic          m_r_ready,
    input  logic [DW-1:0] m_r_data,
    input  logic          m_r_last,
    output logic [1:0]    cur_arb_id
);

    localparam int                 c_ptr_w  = $clog2(OSD_DEPTH);
    localparam logic [c_ptr_w:0]   c_full   = (c_ptr_w+1)'(OSD_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_m_ar_valid;
    logic [AW-1:0]        r_m_ar_addr;
    logic [LW-1:0]        r_m_ar_len;
    logic [1:0]           r_cur_arb_id;
    logic [OSD_DEPTH-1:0] r_osd_id;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;

    logic w_grant_en;
    logic w_grant_id;
    logic w_empty;
    logic w_head;
    logic w_push;
    logic w_pop;

    // Round-robin: prefer the client that was not granted last time.
    always_comb begin
        w_grant_en = (r_state == ST_IDLE) && (r_count < c_full) &&
                     (c0_cmd_valid || c1_cmd_valid);
        if (r_cur_arb_id[0] == 1'b0) begin
            w_grant_id = c1_cmd_valid;
        end else begin
            w_grant_id = !c0_cmd_valid;
        end
    end

    assign c0_cmd_ready = w_grant_en && !w_grant_id;
    assign c1_cmd_ready = w_grant_en &&  w_grant_id;

    assign w_empty = (r_count == '0);
    assign w_head  = r_osd_id[r_rd_ptr];
    assign w_push  = r_m_ar_valid && m_ar_ready;
    assign w_pop   = m_r_valid && m_r_ready && m_r_last;

    assign c0_rd_valid = m_r_valid && !w_empty && !w_head;
    assign c1_rd_valid = m_r_valid && !w_empty &&  w_head;
    assign c0_rd_data  = m_r_data;
    assign c1_rd_data  = m_r_data;
    assign c0_rd_last  = m_r_last;
    assign c1_rd_last  = m_r_last;
    assign m_r_ready   = !w_empty && (w_head ? c1_rd_ready : c0_rd_ready);

    assign m_ar_valid = r_m_ar_valid;
    assign m_ar_addr  = r_m_ar_addr;
    assign m_ar_len   = r_m_ar_len;
    assign cur_arb_id = r_cur_arb_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_m_ar_valid <= 1'b0;
            r_m_ar_addr  <= '0;
            r_m_ar_len   <= '0;
            r_cur_arb_id <= 2'd0;
            r_osd_id     <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_en) begin
                        r_m_ar_addr  <= w_grant_id ? c1_cmd_addr : c0_cmd_addr;
                        r_m_ar_len   <= w_grant_id ? c1_cmd_len  : c0_cmd_len;
                        r_m_ar_valid <= 1'b1;
                        r_cur_arb_id <= {1'b0, w_grant_id};
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_ar_ready) begin
                        r_m_ar_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_push) begin
                r_osd_id[r_wr_ptr] <= r_cur_arb_id[0];
                r_wr_ptr           <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
